// File: rtl/hamming_encoder_tx_pkg.sv
// hamming_encoder_tx_pkg: shared widths, data-to-codeword placement, parity
// cover masks, FIFO occupancy and error-injection state types for the
// SEC-DED (11,6) transmit path.
package hamming_encoder_tx_pkg;

    localparam int CODE_W     = 11;
    localparam int DATA_W     = 6;
    localparam int FIFO_DEPTH = 2;

    // Storage slots of the two-entry FIFO; the head is what OUT_CODE shows
    localparam logic FIFO_HEAD = 1'b0;
    localparam logic FIFO_TAIL = 1'b1;

    // Codeword positions (1-based) receiving IN_DATA[1..6]
    localparam int POS_D1 = 3;
    localparam int POS_D2 = 5;
    localparam int POS_D3 = 6;
    localparam int POS_D4 = 7;
    localparam int POS_D5 = 9;
    localparam int POS_D6 = 10;

    // Data positions covered by each Hamming parity bit (bit k of mask = position k)
    localparam logic [CODE_W:1] P1_COVER = 11'h154;  // positions 3,5,7,9
    localparam logic [CODE_W:1] P2_COVER = 11'h264;  // positions 3,6,7,10
    localparam logic [CODE_W:1] P4_COVER = 11'h070;  // positions 5,6,7
    localparam logic [CODE_W:1] P8_COVER = 11'h300;  // positions 9,10

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_t;

    typedef enum logic {
        INJ_ST_IDLE  = 1'b0,
        INJ_ST_ARMED = 1'b1
    } inj_state_t;

    // Scatter the data bits into their codeword positions, parity slots left at 0
    function automatic logic [CODE_W:1] place_data(input logic [DATA_W:1] data);
        logic [CODE_W:1] code;
        code         = {CODE_W{1'b0}};
        code[POS_D1] = data[1];
        code[POS_D2] = data[2];
        code[POS_D3] = data[3];
        code[POS_D4] = data[4];
        code[POS_D5] = data[5];
        code[POS_D6] = data[6];
        return code;
    endfunction

    // Even parity over the codeword positions selected by cover_mask
    function automatic logic parity_of(input logic [CODE_W:1] code,
                                       input logic [CODE_W:1] cover_mask);
        return ^(code & cover_mask);
    endfunction

endpackage

// File: rtl/hamming_enc_core.sv
// hamming_enc_core: purely combinational SEC-DED (11,6) encoder. Positions
// 1,2,4,8 carry Hamming parity, position 11 makes the whole word even parity.
// Shared with the decoder bench, so it carries no clock or state.
module hamming_enc_core
    import hamming_encoder_tx_pkg::*;
(
    input  logic [DATA_W:1] data,
    output logic [CODE_W:1] code
);

    logic [CODE_W:1] code_s;

    // Place data, then fill the Hamming parity bits and the overall parity bit
    always_comb begin
        code_s     = place_data(data);
        code_s[1]  = parity_of(code_s, P1_COVER);
        code_s[2]  = parity_of(code_s, P2_COVER);
        code_s[4]  = parity_of(code_s, P4_COVER);
        code_s[8]  = parity_of(code_s, P8_COVER);
        code_s[11] = ^code_s[10:1];
    end

    assign code = code_s;

endmodule

// File: rtl/hamming_encoder_tx.sv
// hamming_encoder_tx: encodes 6-bit words into 11-bit SEC-DED codewords and
// buffers them in a two-entry in-order FIFO with valid/ready on both sides.
// WORD_CNT counts delivered codewords modulo 256.
// Optional build macro HAMMING_ERR_INJ_EN adds a one-shot error injector that
// XORs INJ_MASK into the next accepted codeword after INJ_ARM.
module hamming_encoder_tx
    import hamming_encoder_tx_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W:1]   IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [CODE_W:1]   OUT_CODE,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [7:0]        WORD_CNT
`ifdef HAMMING_ERR_INJ_EN
    ,
    input  logic [CODE_W:1]   INJ_MASK,
    input  logic              INJ_ARM,
    output logic              INJ_ARMED
`endif
);

    fifo_state_t      fifo_state_r;
    logic [CODE_W:1]  mem_r [FIFO_DEPTH];
    logic             in_ready_r;
    logic             out_valid_r;
    logic [7:0]       word_cnt_r;

    logic [CODE_W:1]  enc_code_s;
    logic [CODE_W:1]  fifo_code_s;
    logic             push_s;
    logic             pop_s;

    hamming_enc_core u_enc_core (
        .data (IN_DATA),
        .code (enc_code_s)
    );

    // Handshakes are qualified by registered readiness/validity only
    assign push_s = IN_VALID & in_ready_r;
    assign pop_s  = out_valid_r & OUT_READY;

`ifdef HAMMING_ERR_INJ_EN
    inj_state_t inj_state_r;
    logic       inj_armed_r;

    // One-shot injector: arm on request, disarm when the corrupted word is accepted
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            inj_state_r <= INJ_ST_IDLE;
            inj_armed_r <= 1'b0;
        end else begin
            case (inj_state_r)
                INJ_ST_IDLE: begin
                    if (INJ_ARM) begin
                        inj_state_r <= INJ_ST_ARMED;
                        inj_armed_r <= 1'b1;
                    end
                end
                INJ_ST_ARMED: begin
                    if (push_s) begin
                        inj_state_r <= INJ_ST_IDLE;
                        inj_armed_r <= 1'b0;
                    end
                end
                default: begin
                    inj_state_r <= INJ_ST_IDLE;
                    inj_armed_r <= 1'b0;
                end
            endcase
        end
    end

    // Corrupt the codeword entering the FIFO only while armed
    always_comb begin
        fifo_code_s = enc_code_s;
        if (inj_state_r == INJ_ST_ARMED) begin
            fifo_code_s = enc_code_s ^ INJ_MASK;
        end else begin
            fifo_code_s = enc_code_s;
        end
    end

    assign INJ_ARMED = inj_armed_r;
`else
    assign fifo_code_s = enc_code_s;
`endif

    // FIFO occupancy FSM with registered ready/valid; the head slot is zeroed when empty
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            fifo_state_r     <= FIFO_EMPTY;
            mem_r[FIFO_HEAD] <= {CODE_W{1'b0}};
            mem_r[FIFO_TAIL] <= {CODE_W{1'b0}};
            in_ready_r       <= 1'b0;
            out_valid_r      <= 1'b0;
            word_cnt_r       <= 8'd0;
        end else begin
            if (pop_s) begin
                word_cnt_r <= word_cnt_r + 8'd1;
            end
            case (fifo_state_r)
                FIFO_EMPTY: begin
                    in_ready_r <= 1'b1;
                    if (push_s) begin
                        mem_r[FIFO_HEAD] <= fifo_code_s;
                        fifo_state_r     <= FIFO_ONE;
                        out_valid_r      <= 1'b1;
                    end else begin
                        out_valid_r      <= 1'b0;
                    end
                end
                FIFO_ONE: begin
                    if (push_s && pop_s) begin
                        // Head leaves and the new word takes its place
                        mem_r[FIFO_HEAD] <= fifo_code_s;
                        in_ready_r       <= 1'b1;
                        out_valid_r      <= 1'b1;
                    end else if (push_s) begin
                        mem_r[FIFO_TAIL] <= fifo_code_s;
                        fifo_state_r     <= FIFO_FULL;
                        in_ready_r       <= 1'b0;
                        out_valid_r      <= 1'b1;
                    end else if (pop_s) begin
                        mem_r[FIFO_HEAD] <= {CODE_W{1'b0}};
                        fifo_state_r     <= FIFO_EMPTY;
                        in_ready_r       <= 1'b1;
                        out_valid_r      <= 1'b0;
                    end else begin
                        in_ready_r       <= 1'b1;
                        out_valid_r      <= 1'b1;
                    end
                end
                FIFO_FULL: begin
                    out_valid_r <= 1'b1;
                    if (pop_s) begin
                        mem_r[FIFO_HEAD] <= mem_r[FIFO_TAIL];
                        mem_r[FIFO_TAIL] <= {CODE_W{1'b0}};
                        fifo_state_r     <= FIFO_ONE;
                        in_ready_r       <= 1'b1;
                    end else begin
                        in_ready_r       <= 1'b0;
                    end
                end
                default: begin
                    fifo_state_r     <= FIFO_EMPTY;
                    mem_r[FIFO_HEAD] <= {CODE_W{1'b0}};
                    mem_r[FIFO_TAIL] <= {CODE_W{1'b0}};
                    in_ready_r       <= 1'b1;
                    out_valid_r      <= 1'b0;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_r;
    assign OUT_VALID = out_valid_r;
    assign OUT_CODE  = mem_r[FIFO_HEAD];
    assign WORD_CNT  = word_cnt_r;

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// tb_hamming_encoder_tx: directed self-checking bench for hamming_encoder_tx.
// Expected codewords come from an independent position-based Hamming model and
// are queued on each input handshake, then popped and compared on each output
// handshake. Inputs change on the falling edge; outputs are sampled there too.
module tb_hamming_encoder_tx;

    logic        CLK;
    logic        RST_N;
    logic [6:1]  IN_DATA;
    logic        IN_VALID;
    logic        IN_READY;
    logic [11:1] OUT_CODE;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [7:0]  WORD_CNT;
`ifdef HAMMING_ERR_INJ_EN
    logic [11:1] INJ_MASK;
    logic        INJ_ARM;
    logic        INJ_ARMED;
`endif

    int          n_checks;
    int          n_fail;
    int          delivered;
    logic [11:1] exp_q [$];
    logic        inj_pending;
    logic [11:1] inj_mask_model;

    hamming_encoder_tx dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OUT_CODE  (OUT_CODE),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .WORD_CNT  (WORD_CNT)
`ifdef HAMMING_ERR_INJ_EN
        ,
        .INJ_MASK  (INJ_MASK),
        .INJ_ARM   (INJ_ARM),
        .INJ_ARMED (INJ_ARMED)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Textbook Hamming: parity bit p covers every position k with (k & p) != 0
    function automatic logic [11:1] model_encode(input logic [6:1] d);
        logic [11:1] c;
        int          pos [6];
        logic        x;
        pos = '{3, 5, 6, 7, 9, 10};
        c = 11'h000;
        for (int i = 0; i < 6; i++) c[pos[i]] = d[i + 1];
        for (int p = 1; p <= 8; p = p * 2) begin
            x = 1'b0;
            for (int k = 1; k <= 10; k++) begin
                if (((k & p) != 0) && (k != p)) x = x ^ c[k];
            end
            c[p] = x;
        end
        c[11] = ^c[10:1];
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: score handshakes seen before the rising edge, end at the next falling edge
    task automatic cycle();
        logic        in_hs;
        logic        out_hs;
        logic [11:1] e;
        in_hs  = RST_N && IN_VALID && IN_READY;
        out_hs = RST_N && OUT_VALID && OUT_READY;
        if (out_hs) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL out_unexpected: observed 0x%0h expected no output", OUT_CODE);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_code_order", 32'(OUT_CODE), 32'(e));
            end
            delivered++;
        end
        if (in_hs) begin
            e = model_encode(IN_DATA);
            if (inj_pending) begin
                e = e ^ inj_mask_model;
                inj_pending = 1'b0;
            end
            exp_q.push_back(e);
        end
        @(posedge CLK);
        if (!RST_N) begin
            exp_q.delete();
            delivered = 0;
        end
        @(negedge CLK);
    endtask

    logic [6:1]  vec_data [3];
    logic [11:1] vec_code [3];

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        delivered      = 0;
        inj_pending    = 1'b0;
        inj_mask_model = 11'h000;
        RST_N          = 1'b0;
        IN_DATA        = 6'd0;
        IN_VALID       = 1'b0;
        OUT_READY      = 1'b0;
`ifdef HAMMING_ERR_INJ_EN
        INJ_MASK       = 11'h000;
        INJ_ARM        = 1'b0;
`endif

        // Reset state
        cycle();
        cycle();
        check("rst_in_ready",  32'(IN_READY),  32'd0);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_out_code",  32'(OUT_CODE),  32'd0);
        check("rst_word_cnt",  32'(WORD_CNT),  32'd0);

        RST_N = 1'b1;
        cycle();
        check("first_edge_in_ready", 32'(IN_READY),  32'd1);
        check("first_edge_out_valid", 32'(OUT_VALID), 32'd0);

        // Known codewords with one-cycle latency
        vec_data = '{6'b000000, 6'b000001, 6'b111111};
        vec_code = '{11'h000, 11'h407, 11'h77C};
        OUT_READY = 1'b1;
        for (int v = 0; v < 3; v++) begin
            IN_DATA  = vec_data[v];
            IN_VALID = 1'b1;
            cycle();
            IN_VALID = 1'b0;
            check("vec_out_valid", 32'(OUT_VALID), 32'd1);
            check("vec_out_code",  32'(OUT_CODE),  32'(vec_code[v]));
            cycle();
            check("vec_drained_valid", 32'(OUT_VALID), 32'd0);
            check("vec_idle_code_zero", 32'(OUT_CODE), 32'd0);
        end
        check("word_cnt_after_vec", 32'(WORD_CNT), 32'(delivered));

        // Backpressure: two accepted, third held until a pop
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        IN_DATA   = 6'h15;
        cycle();
        check("bp_ready_one", 32'(IN_READY), 32'd1);
        IN_DATA = 6'h2A;
        cycle();
        check("bp_ready_full", 32'(IN_READY), 32'd0);
        check("bp_valid_full", 32'(OUT_VALID), 32'd1);
        IN_DATA = 6'h0C;
        cycle();
        check("bp_third_blocked", 32'(IN_READY), 32'd0);
        check("bp_code_stable", 32'(OUT_CODE), 32'(exp_q[0]));
        check("bp_queue_two", 32'(exp_q.size()), 32'd2);
        OUT_READY = 1'b1;
        cycle();
        check("bp_ready_after_pop", 32'(IN_READY), 32'd1);
        cycle();
        check("bp_third_in_ready", 32'(IN_READY), 32'd1);
        check("bp_third_valid", 32'(OUT_VALID), 32'd1);
        IN_VALID = 1'b0;
        cycle();
        check("bp_drained", 32'(OUT_VALID), 32'd0);
        check("bp_word_cnt", 32'(WORD_CNT), 32'(delivered));

        // ONE with simultaneous push and pop
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        IN_DATA   = 6'h33;
        cycle();
        IN_DATA   = 6'h0F;
        OUT_READY = 1'b1;
        cycle();
        IN_VALID = 1'b0;
        check("pp_stays_one_ready", 32'(IN_READY),  32'd1);
        check("pp_stays_one_valid", 32'(OUT_VALID), 32'd1);
        check("pp_new_head", 32'(OUT_CODE), 32'(model_encode(6'h0F)));
        check("pp_word_cnt", 32'(WORD_CNT), 32'(delivered));
        cycle();
        check("pp_drained", 32'(OUT_VALID), 32'd0);
        check("pp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset while FULL drops everything
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        IN_DATA   = 6'h21;
        cycle();
        IN_DATA = 6'h12;
        cycle();
        check("rf_full", 32'(IN_READY), 32'd0);
        RST_N     = 1'b0;
        OUT_READY = 1'b1;
        cycle();
        check("rf_out_valid", 32'(OUT_VALID), 32'd0);
        check("rf_word_cnt",  32'(WORD_CNT),  32'd0);
        check("rf_out_code",  32'(OUT_CODE),  32'd0);
        RST_N    = 1'b1;
        IN_VALID = 1'b0;
        cycle();
        check("rf_ready_after", 32'(IN_READY),  32'd1);
        check("rf_nothing_kept", 32'(OUT_VALID), 32'd0);

        // 257 deliveries wrap the counter to 1
        OUT_READY = 1'b1;
        IN_VALID  = 1'b1;
        for (int n = 0; n < 257; n++) begin
            IN_DATA = 6'($urandom_range(0, 63));
            cycle();
        end
        IN_VALID = 1'b0;
        cycle();
        check("wrap_delivered", 32'(delivered), 32'd257);
        check("wrap_word_cnt", 32'(WORD_CNT), 32'd1);
        check("wrap_drained", 32'(OUT_VALID), 32'd0);

`ifdef HAMMING_ERR_INJ_EN
        // One-shot injection; second arm pulse while armed is ignored
        check("inj_idle", 32'(INJ_ARMED), 32'd0);
        INJ_MASK = 11'h004;
        INJ_ARM  = 1'b1;
        cycle();
        check("inj_armed", 32'(INJ_ARMED), 32'd1);
        cycle();
        INJ_ARM = 1'b0;
        check("inj_rearm_ignored", 32'(INJ_ARMED), 32'd1);
        inj_pending    = 1'b1;
        inj_mask_model = 11'h004;
        IN_DATA        = 6'b000001;
        IN_VALID       = 1'b1;
        cycle();
        check("inj_disarmed", 32'(INJ_ARMED), 32'd0);
        check("inj_code", 32'(OUT_CODE), 32'h403);
        cycle();
        IN_VALID = 1'b0;
        check("inj_next_clean", 32'(OUT_CODE), 32'h407);
        cycle();
        check("inj_drained", 32'(OUT_VALID), 32'd0);
`endif

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
